wash_cycle_sequencer: RTL and testbench
=======================================

Name: wash_cycle_sequencer

Overview:
- Timed phase controller for the washing machine.
- Walks Off → Idle → Wash_fill/agitate/spin → Rinse_fill/agitate/spin → Idle, holding each timed phase for a programmable number of clocks.
- Handles the water-level fill handshake, fill timeout, door interlock with pause/resume, and start/done signalling.
- Drives valve, motor and door-lock outputs for the machine datapath.

Parameters:
- CNT_W, 16: width of the phase counter; all tick parameters must be < 2^CNT_W and ≥ 1.
- AGITATE_TICKS, 1000: clocks spent in each agitate phase.
- SPIN_TICKS, 500: clocks spent in each spin phase.
- FILL_TIMEOUT, 2000: max clocks in a fill phase before fault.

Ports:
- clkorig  in  1  system clock, rising edge.
- power  in  1  asynchronous active-low reset (0 = machine off).
- start  in  1  start request, sampled only in Idle.
- door  in  1  door sensor, 1 = open.
- water_full  in  1  level sensor, 1 = drum full.
- state  out  3  current phase: Off=0, Idle=1, Wash_fill=2, Wash_agitate=3, Wash_spin=4, Rinse_fill=5, Rinse_agitate=6, Rinse_spin=7.
- water  out  2  valves; MSB = hot, LSB = cold.
- motor  out  2  00 off, 01 agitate, 10 spin; 11 never driven.
- door_lock  out  1  1 in states 2..7.
- paused  out  1  1 while an active phase is frozen by an open door.
- done  out  1  one-cycle pulse on normal cycle completion.
- fault  out  1  sticky fill-timeout flag.

Behaviour:
- Reset (power=0, async): state=Off, counter=0, water=00, motor=00, door_lock=0, paused=0, done=0, fault=0.
- All outputs are registered and change on the same edge as state.
- Off: first clock after reset release goes to Idle unconditionally.
- Idle:
  - start=1 and door=0 → Wash_fill next edge; counter cleared; fault cleared on the same edge.
  - start while door=1 is ignored.
- Fill phases (2, 5):
  - water=10 in Wash_fill, 01 in Rinse_fill; motor=00.
  - Each cycle in fill with water_full=1 → next agitate state, counter cleared.
  - Counter increments each non-paused fill cycle. When counter==FILL_TIMEOUT-1 and water_full=0 → Idle, fault=1, water=00.
  - If water_full=1 on that same cycle, water_full wins.
- Agitate phases (3, 6):
  - motor=01; water holds the fill code (10 or 01).
  - Leave when counter==AGITATE_TICKS-1 → next spin state, counter cleared.
- Spin phases (4, 7):
  - motor=10, water=00.
  - Leave when counter==SPIN_TICKS-1.
  - Wash_spin → Rinse_fill.
  - Rinse_spin → Idle with done=1 for exactly that one cycle.
- Phase residency: exactly N clocks for an N-tick phase (counter 0..N-1); no wrap-around is possible.
- Door open in states 2..7:
  - Next edge: paused=1, water=00, motor=00.
  - state and counter hold; no transitions, timeouts or fill completions occur.
  - door_lock stays 1.
- Door close while paused:
  - Next edge: paused=0, outputs restored to the phase's codes, counting resumes from the held value.
- start outside Idle is ignored. water_full outside fill phases is ignored.
- Reset mid-cycle: immediate Off with all outputs at reset values. No resume; a new start is required after Idle.

Decomposition:
- Package wm_pkg: state localparams (3-bit encodings above), water codes (WATER_OFF=00, WATER_HOT=10, WATER_COLD=01), motor codes (MOTOR_OFF, MOTOR_AGITATE, MOTOR_SPIN).
- Sub-module phase_timer:
  - CNT_W-bit counter with clear, hold (pause) and a compare input giving a registered-free expire flag (count == limit-1).
  - Sequencer muxes the limit by state.

Test Plan (AGITATE_TICKS=4, SPIN_TICKS=3, FILL_TIMEOUT=8):
- Release power, start=1 pulse, door=0, water_full=1 → state 0,1,2,3×4,4×3,5,6×4,7×3,1. done=1 only on the return-to-1 cycle; total 16 clocks from entering 2 to entering 1.
- water_full held 0 in Wash_fill → after 8 cycles in state 2, state=1 and fault=1. Next start clears fault and enters state 2.
- door=1 for 5 cycles at counter=2 of Wash_agitate → paused=1, motor=00, state=3 for 5 cycles. After close, exactly 2 more agitate cycles, then state 4.
- start=1 with door=1 in Idle → remains state 1. start pulses during Wash_spin → no effect on sequence.
- power→0 mid Rinse_agitate → same-instant state=0, water=00, motor=00, door_lock=0. After release: 0, then 1, waiting for start.
- water_full=1 on the timeout cycle (counter=7) of Rinse_fill → state 6, fault stays 0.

Source files
------------

// File: rtl/wash_cycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wm_pkg
// Shared encodings for the wash cycle sequencer: the phase state type,
// valve and motor output codes, and small helpers that map a phase to its
// output codes.
// ---------------------------------------------------------------------------
package wm_pkg;

  // Phase encodings are visible on the state output, so values are fixed.
  typedef enum logic [2:0] {
    ST_OFF           = 3'd0,
    ST_IDLE          = 3'd1,
    ST_WASH_FILL     = 3'd2,
    ST_WASH_AGITATE  = 3'd3,
    ST_WASH_SPIN     = 3'd4,
    ST_RINSE_FILL    = 3'd5,
    ST_RINSE_AGITATE = 3'd6,
    ST_RINSE_SPIN    = 3'd7
  } state_t;

  // Valve codes: MSB = hot, LSB = cold.
  localparam logic [1:0] WATER_OFF  = 2'b00;
  localparam logic [1:0] WATER_HOT  = 2'b10;
  localparam logic [1:0] WATER_COLD = 2'b01;

  // Motor codes; 2'b11 is never driven.
  localparam logic [1:0] MOTOR_OFF     = 2'b00;
  localparam logic [1:0] MOTOR_AGITATE = 2'b01;
  localparam logic [1:0] MOTOR_SPIN    = 2'b10;

  // True for the timed phases, where the door is locked.
  function automatic logic is_active(input state_t s);
    logic act;
    case (s)
      ST_OFF, ST_IDLE: act = 1'b0;
      default:         act = 1'b1;
    endcase
    return act;
  endfunction

  // Valve code for a phase; agitate keeps the fill code of its half-cycle.
  function automatic logic [1:0] water_code(input state_t s, input logic paused);
    logic [1:0] w;
    case (s)
      ST_WASH_FILL, ST_WASH_AGITATE:   w = WATER_HOT;
      ST_RINSE_FILL, ST_RINSE_AGITATE: w = WATER_COLD;
      default:                         w = WATER_OFF;
    endcase
    if (paused) begin
      w = WATER_OFF;
    end
    return w;
  endfunction

  // Motor code for a phase.
  function automatic logic [1:0] motor_code(input state_t s, input logic paused);
    logic [1:0] m;
    case (s)
      ST_WASH_AGITATE, ST_RINSE_AGITATE: m = MOTOR_AGITATE;
      ST_WASH_SPIN, ST_RINSE_SPIN:       m = MOTOR_SPIN;
      default:                           m = MOTOR_OFF;
    endcase
    if (paused) begin
      m = MOTOR_OFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// wash_cycle_sequencer_if
// Machine-side signal bundle of the wash cycle sequencer.
//   start, door, water_full : requests/sensors into the sequencer
//   state, water, motor     : current phase and actuator codes
//   door_lock, paused       : interlock status
//   done, fault             : completion pulse and sticky fill-timeout flag
// master: the machine/controller side (drives sensors, reads status).
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface wash_cycle_sequencer_if;
  logic       start;
  logic       door;
  logic       water_full;
  logic [2:0] state;
  logic [1:0] water;
  logic [1:0] motor;
  logic       door_lock;
  logic       paused;
  logic       done;
  logic       fault;

  modport master (
    output start, door, water_full,
    input  state, water, motor, door_lock, paused, done, fault
  );

  modport slave (
    input  start, door, water_full,
    output state, water, motor, door_lock, paused, done, fault
  );
endinterface

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Phase residency counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count at zero on the next edge
//   hold       : freeze the count (door open)
//   limit      : residency of the current phase in clocks (>= 1)
//   expire     : combinational, high while count == limit-1
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count clocks in the current phase; clear wins over hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!hold) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Last clock of the phase; the sequencer leaves on this cycle, so the
  // count never reaches limit and cannot wrap.
  always_comb begin
    expire = (cnt_r == (limit - ONE));
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// wash_cycle_sequencer
// Timed phase controller: Off -> Idle -> wash fill/agitate/spin ->
// rinse fill/agitate/spin -> Idle, with fill handshake, fill timeout and
// door pause/resume.
//   clkorig : system clock, rising edge
//   power   : asynchronous active-low reset (0 = machine off)
//   bus     : slave side of wash_cycle_sequencer_if (sensors in, phase and
//             actuator codes out; every output is registered)
// ---------------------------------------------------------------------------
module wash_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned AGITATE_TICKS = 1000,
  parameter int unsigned SPIN_TICKS    = 500,
  parameter int unsigned FILL_TIMEOUT  = 2000
) (
  input  logic                   clkorig,
  input  logic                   power,
  wash_cycle_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] AGITATE_LIM = AGITATE_TICKS[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SPIN_LIM    = SPIN_TICKS[CNT_W-1:0];
  localparam logic [CNT_W-1:0] FILL_LIM    = FILL_TIMEOUT[CNT_W-1:0];

  state_t           state_r;
  logic [1:0]       water_r;
  logic [1:0]       motor_r;
  logic             door_lock_r;
  logic             paused_r;
  logic             done_r;
  logic             fault_r;

  state_t           nxt_state_s;
  logic             nxt_paused_s;
  logic             tmr_clr_s;
  logic             tmr_hold_s;
  logic [CNT_W-1:0] limit_s;
  logic             expire_s;
  logic             fault_set_s;
  logic             fault_clr_s;
  logic             done_s;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clkorig),
    .rst_n  (power),
    .clr    (tmr_clr_s),
    .hold   (tmr_hold_s),
    .limit  (limit_s),
    .expire (expire_s)
  );

  // Next phase, timer control and event strobes. An open door in any timed
  // phase freezes everything (state, count, fill completion, timeout).
  always_comb begin
    nxt_state_s  = state_r;
    nxt_paused_s = 1'b0;
    tmr_clr_s    = 1'b0;
    tmr_hold_s   = 1'b0;
    limit_s      = FILL_LIM;
    fault_set_s  = 1'b0;
    fault_clr_s  = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_OFF: begin
        nxt_state_s = ST_IDLE;
        tmr_clr_s   = 1'b1;
      end
      ST_IDLE: begin
        tmr_clr_s = 1'b1;
        if (bus.start && !bus.door) begin
          nxt_state_s = ST_WASH_FILL;
          fault_clr_s = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_WASH_FILL, ST_RINSE_FILL: begin
        limit_s = FILL_LIM;
        if (bus.door) begin
          tmr_hold_s   = 1'b1;
          nxt_paused_s = 1'b1;
        end else if (bus.water_full) begin
          // A full drum beats a simultaneous timeout.
          nxt_state_s = (state_r == ST_WASH_FILL) ? ST_WASH_AGITATE : ST_RINSE_AGITATE;
          tmr_clr_s   = 1'b1;
        end else if (expire_s) begin
          nxt_state_s = ST_IDLE;
          tmr_clr_s   = 1'b1;
          fault_set_s = 1'b1;
        end else begin
          nxt_state_s = state_r;
        end
      end
      ST_WASH_AGITATE, ST_RINSE_AGITATE: begin
        limit_s = AGITATE_LIM;
        if (bus.door) begin
          tmr_hold_s   = 1'b1;
          nxt_paused_s = 1'b1;
        end else if (expire_s) begin
          nxt_state_s = (state_r == ST_WASH_AGITATE) ? ST_WASH_SPIN : ST_RINSE_SPIN;
          tmr_clr_s   = 1'b1;
        end else begin
          nxt_state_s = state_r;
        end
      end
      ST_WASH_SPIN, ST_RINSE_SPIN: begin
        limit_s = SPIN_LIM;
        if (bus.door) begin
          tmr_hold_s   = 1'b1;
          nxt_paused_s = 1'b1;
        end else if (expire_s) begin
          tmr_clr_s = 1'b1;
          if (state_r == ST_WASH_SPIN) begin
            nxt_state_s = ST_RINSE_FILL;
          end else begin
            nxt_state_s = ST_IDLE;
            done_s      = 1'b1;
          end
        end else begin
          nxt_state_s = state_r;
        end
      end
      default: begin
        nxt_state_s = ST_OFF;
        tmr_clr_s   = 1'b1;
      end
    endcase
  end

  // Phase register plus all outputs, derived from the next phase so they
  // change on the same edge as state.
  always_ff @(posedge clkorig or negedge power) begin
    if (!power) begin
      state_r     <= ST_OFF;
      water_r     <= WATER_OFF;
      motor_r     <= MOTOR_OFF;
      door_lock_r <= 1'b0;
      paused_r    <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      water_r     <= water_code(nxt_state_s, nxt_paused_s);
      motor_r     <= motor_code(nxt_state_s, nxt_paused_s);
      door_lock_r <= is_active(nxt_state_s);
      paused_r    <= nxt_paused_s;
      done_r      <= done_s;
      if (fault_clr_s) begin
        fault_r <= 1'b0;
      end else if (fault_set_s) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  assign bus.state     = state_r;
  assign bus.water     = water_r;
  assign bus.motor     = motor_r;
  assign bus.door_lock = door_lock_r;
  assign bus.paused    = paused_r;
  assign bus.done      = done_r;
  assign bus.fault     = fault_r;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wash_cycle_sequencer
// Directed bench with AGITATE_TICKS=4, SPIN_TICKS=3, FILL_TIMEOUT=8.
// The driver pushes the hand-derived output snapshot expected after each
// edge; a monitor pops and compares on the falling edge (or immediately on
// chk_ev for asynchronous reset checks).
// ---------------------------------------------------------------------------
module tb_wash_cycle_sequencer;

  logic clk   = 1'b0;
  logic power = 1'b0;

  always #5 clk = ~clk;

  wash_cycle_sequencer_if bus ();

  wash_cycle_sequencer #(
    .CNT_W         (16),
    .AGITATE_TICKS (4),
    .SPIN_TICKS    (3),
    .FILL_TIMEOUT  (8)
  ) dut (
    .clkorig (clk),
    .power   (power),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] w;
    logic [1:0] m;
    logic       dl;
    logic       p;
    logic       d;
    logic       f;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  event  chk_ev;

  // Normal-cycle states seen after each edge, starting from Wash_fill.
  int seq_full [16] = '{3, 3, 3, 3, 4, 4, 4, 5, 6, 6, 6, 6, 7, 7, 7, 1};

  // Expected output snapshot from the output table of each phase.
  function automatic exp_t mk(input int st, input bit p, input bit d, input bit f);
    exp_t e;
    e.st = st[2:0];
    case (st)
      2, 3:    e.w = 2'b10;
      5, 6:    e.w = 2'b01;
      default: e.w = 2'b00;
    endcase
    case (st)
      3, 6:    e.m = 2'b01;
      4, 7:    e.m = 2'b10;
      default: e.m = 2'b00;
    endcase
    if (p) begin
      e.w = 2'b00;
      e.m = 2'b00;
    end
    e.dl = (st >= 2);
    e.p  = p;
    e.d  = d;
    e.f  = f;
    return e;
  endfunction

  task automatic push(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Apply inputs for one clock and queue the expectation after that edge.
  task automatic cyc(input bit s, input bit d, input bit wf, input exp_t e, input string nm);
    bus.start      = s;
    bus.door       = d;
    bus.water_full = wf;
    @(posedge clk);
    push(e, nm);
    #1;
  endtask

  // Check the current outputs right now (used around asynchronous reset).
  task automatic chk_now(input exp_t e, input string nm);
    push(e, nm);
    -> chk_ev;
    #1;
  endtask

  exp_t  got_v;
  exp_t  want_v;
  string nm_v;

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        want_v = exp_q.pop_front();
        nm_v   = name_q.pop_front();
        got_v  = {bus.state, bus.water, bus.motor, bus.door_lock,
                  bus.paused, bus.done, bus.fault};
        tests_run++;
        if (got_v !== want_v) begin
          tests_failed++;
          $display("FAIL %s: got st=%0d w=%b m=%b lock=%b p=%b done=%b fault=%b, expected st=%0d w=%b m=%b lock=%b p=%b done=%b fault=%b",
                   nm_v, got_v.st, got_v.w, got_v.m, got_v.dl, got_v.p, got_v.d, got_v.f,
                   want_v.st, want_v.w, want_v.m, want_v.dl, want_v.p, want_v.d, want_v.f);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.door       = 1'b0;
    bus.water_full = 1'b0;

    // Reset state and Off -> Idle.
    repeat (2) @(posedge clk);
    #1;
    chk_now(mk(0, 0, 0, 0), "reset");
    @(negedge clk); #1;
    power = 1'b1; #1;
    chk_now(mk(0, 0, 0, 0), "off_after_release");
    cyc(1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0), "off_to_idle");

    // Full normal cycle; start pulses during Wash_spin are ignored.
    cyc(1'b1, 1'b0, 1'b1, mk(2, 0, 0, 0), "start_to_wash_fill");
    for (int i = 0; i < 16; i++) begin
      cyc((i >= 5 && i <= 7), 1'b0, 1'b1, mk(seq_full[i], 0, (i == 15), 0), "normal_cycle");
    end
    cyc(1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0), "done_one_cycle");

    // Fill timeout in Wash_fill.
    cyc(1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0), "start_timeout_run");
    repeat (7) cyc(1'b0, 1'b0, 1'b0, mk(2, 0, 0, 0), "fill_wait");
    cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1), "fill_timeout");
    cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1), "fault_sticky");
    cyc(1'b1, 1'b1, 1'b0, mk(1, 0, 0, 1), "start_door_open_ignored");
    cyc(1'b1, 1'b0, 1'b0, mk(2, 0, 0, 0), "restart_clears_fault");

    // Door pause at counter=2 of Wash_agitate.
    cyc(1'b0, 1'b0, 1'b1, mk(3, 0, 0, 0), "fill_complete");
    cyc(1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0), "agitate_c0");
    cyc(1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0), "agitate_c1");
    repeat (5) cyc(1'b0, 1'b1, 1'b0, mk(3, 1, 0, 0), "paused");
    cyc(1'b0, 1'b0, 1'b0, mk(3, 0, 0, 0), "resume");
    cyc(1'b0, 1'b0, 1'b0, mk(4, 0, 0, 0), "agitate_to_spin");
    repeat (2) cyc(1'b0, 1'b0, 1'b0, mk(4, 0, 0, 0), "wash_spin");
    cyc(1'b0, 1'b0, 1'b0, mk(5, 0, 0, 0), "spin_to_rinse_fill");

    // water_full on the timeout cycle of Rinse_fill wins.
    repeat (7) cyc(1'b0, 1'b0, 1'b0, mk(5, 0, 0, 0), "rinse_fill_wait");
    cyc(1'b0, 1'b0, 1'b1, mk(6, 0, 0, 0), "full_wins_on_timeout");
    cyc(1'b0, 1'b0, 1'b0, mk(6, 0, 0, 0), "rinse_agitate");

    // Power loss mid Rinse_agitate.
    @(negedge clk); #1;
    power = 1'b0; #1;
    chk_now(mk(0, 0, 0, 0), "reset_mid_cycle");
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "held_in_reset");
    @(negedge clk); #1;
    power = 1'b1; #1;
    chk_now(mk(0, 0, 0, 0), "off_after_re_release");
    cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0), "reenter_idle");
    cyc(1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0), "wait_for_start");

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
